config_chain_loader: RTL and testbench

//   Loads the fabric configuration shift chain that feeds the routing-mux selectors
//   (SB/IC multiplexer config bits) and other tile config registers.

---
 rtl/config_chain_loader.sv | 106 ++++++++++
 tb/tb_config_chain_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Serializes bitstream words LSB-first onto the fabric configuration shift chain
// and stops after exactly CHAIN_LENGTH shifted bits.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int BL_W  = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LENGTH);
  localparam logic [BL_W-1:0]  FULL_WORD = BL_W'(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic [BL_W-1:0]         bits_left_q, bits_left_d;
  logic [CNT_W-1:0]        bit_count_q, bit_count_d;
  logic                    ready_q, ready_d;
  logic                    cfg_out_q, cfg_out_d;
  logic                    cfg_en_q, cfg_en_d;
  logic                    accept;

  // ready_q is only ever set while loading, so no state qualifier is needed here
  assign accept = ready_q & data_valid;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bits_left_d = bits_left_q;
    bit_count_d = bit_count_q;
    cfg_out_d   = 1'b0;
    cfg_en_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          bits_left_d = '0;
          bit_count_d = '0;
        end
      end
      LOAD: begin
        if (bit_count_q == LAST_BIT) begin
          // unshifted bits of the final word are dropped here
          state_d     = DONE;
          bits_left_d = '0;
        end else if (accept) begin
          word_d      = data_in >> 1;
          bits_left_d = FULL_WORD;
          cfg_out_d   = data_in[0];
          cfg_en_d    = 1'b1;
          bit_count_d = bit_count_q + CNT_W'(1);
        end else if (bits_left_q != '0) begin
          // bits_left counts the bit on the output plus those still queued in word_q
          bits_left_d = bits_left_q - BL_W'(1);
          if (bits_left_q != BL_W'(1)) begin
            word_d      = word_q >> 1;
            cfg_out_d   = word_q[0];
            cfg_en_d    = 1'b1;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD) && (bits_left_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bits_left_q <= '0;
      bit_count_q <= '0;
      ready_q     <= 1'b0;
      cfg_out_q   <= 1'b0;
      cfg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bits_left_q <= bits_left_d;
      bit_count_q <= bit_count_d;
      ready_q     <= ready_d;
      cfg_out_q   <= cfg_out_d;
      cfg_en_q    <= cfg_en_d;
    end
  end

  assign data_ready    = ready_q;
  assign config_out    = cfg_out_q;
  assign config_enable = cfg_en_q;
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the loader.
module tb_config_chain_loader;

  localparam int W  = 8;
  localparam int CL = 20;

  logic         clock = 1'b0;
  logic         nreset, start, data_valid;
  logic [W-1:0] data_in;
  logic         data_ready, config_out, config_enable, busy, done;

  always #5 clock = ~clock;

  config_chain_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(CL)) dut (
    .clock(clock), .nreset(nreset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .config_out(config_out),
    .config_enable(config_enable), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=load 2=done; m_rest holds the word's bits not yet shown
  int m_mode = 0;
  int m_shifted = 0;
  bit m_en = 0, m_out = 0, m_ready = 0, m_acc = 0;
  bit m_rest[$];

  function automatic void model_edge();
    m_acc = 0;
    if (!nreset) begin
      m_mode = 0; m_en = 0; m_out = 0; m_shifted = 0; m_rest.delete();
    end else if (m_mode == 1) begin
      if (m_shifted == CL) begin
        m_mode = 2; m_en = 0; m_out = 0; m_rest.delete();
      end else if (m_ready && data_valid) begin
        m_acc = 1;
        m_rest.delete();
        for (int i = 0; i < W; i++) m_rest.push_back(data_in[i]);
        m_out = m_rest.pop_front(); m_en = 1; m_shifted++;
      end else if (m_rest.size() > 0) begin
        m_out = m_rest.pop_front(); m_en = 1; m_shifted++;
      end else begin
        m_en = 0; m_out = 0;
      end
    end else if (start) begin
      m_mode = 1; m_shifted = 0; m_en = 0; m_out = 0; m_rest.delete();
    end
    m_ready = (m_mode == 1) && !m_en;
  endfunction

  bit obs[$];
  bit en_prev = 0, en_now = 0;

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_eq("ready", 32'(data_ready), 32'(m_ready));
    check_eq("enable", 32'(config_enable), 32'(m_en));
    if (m_en) check_eq("serial", 32'(config_out), 32'(m_out));
    check_eq("busy", 32'(busy), 32'(m_mode == 1));
    check_eq("done", 32'(done), 32'(m_mode == 2));
    en_prev = en_now;
    en_now  = (config_enable === 1'b1);
    if (en_now) obs.push_back(config_out);
  endtask

  function automatic logic [31:0] packed_obs();
    logic [31:0] v = '0;
    foreach (obs[i]) if (i < 32) v[i] = obs[i];
    return v;
  endfunction

  task automatic feed_word(input logic [W-1:0] w, input int gap);
    bit got = 0;
    data_valid = 1'b1;
    data_in    = w;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_acc) begin got = 1; break; end
    end
    data_valid = 1'b0;
    check_eq("accept_in_time", 32'(got), 32'd1);
    repeat (gap) cycle();
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) break;
      cycle();
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("done_after_last_bit", 32'(en_prev), 32'd1);
  endtask

  task automatic begin_load();
    obs.delete();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  logic [W-1:0]  w0, w1, w2;
  logic [23:0]   words;

  initial begin
    nreset = 1'b0; start = 1'b0; data_valid = 1'b1; data_in = 8'hFF;

    // reset with data_valid held high
    cycle(); cycle();
    check_eq("rst_ready", 32'(data_ready), 32'd0);
    check_eq("rst_enable", 32'(config_enable), 32'd0);
    check_eq("rst_out", 32'(config_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    nreset = 1'b1;
    repeat (3) cycle();
    check_eq("idle_valid_ignored", 32'(obs.size()), 32'd0);
    data_valid = 1'b0;

    // full load with continuous words
    begin_load();
    feed_word(8'hA5, 0); feed_word(8'h3C, 0); feed_word(8'h0F, 0);
    wait_done(40);
    check_eq("full_count", 32'(obs.size()), 32'd20);
    check_eq("full_bits", packed_obs(), 32'h000F3CA5);
    data_valid = 1'b1; data_in = 8'h77;
    repeat (4) cycle();
    data_valid = 1'b0;
    check_eq("done_valid_ignored", 32'(obs.size()), 32'd20);
    check_eq("done_hold", 32'(done), 32'd1);

    // stalled source, with a start pulse during the stall
    begin_load();
    for (int wi = 0; wi < 2; wi++) begin
      feed_word(wi == 0 ? 8'hA5 : 8'h3C, 8);
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        cycle();
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_enable", 32'(config_enable), 32'd0);
      end
      start = 1'b0;
    end
    feed_word(8'h0F, 0);
    wait_done(40);
    check_eq("stall_count", 32'(obs.size()), 32'd20);
    check_eq("stall_bits", packed_obs(), 32'h000F3CA5);

    // handshake timing on the first word of a load
    begin_load();
    for (int i = 0; i < 10; i++) begin
      if (data_ready === 1'b1) break;
      cycle();
    end
    check_eq("hs_ready_N", 32'(data_ready), 32'd1);
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    data_valid = 1'b1; data_in = w0;
    cycle();
    data_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      check_eq("hs_enable_high", 32'(config_enable), 32'd1);
      check_eq("hs_ready_low", 32'(data_ready), 32'd0);
      cycle();
    end
    check_eq("hs_ready_N9", 32'(data_ready), 32'd1);
    check_eq("hs_enable_N9", 32'(config_enable), 32'd0);
    feed_word(w1, 0); feed_word(w2, 0);
    wait_done(40);
    words = {w2, w1, w0};
    check_eq("hs_count", 32'(obs.size()), 32'd20);
    check_eq("hs_bits", packed_obs(), 32'(words[19:0]));

    // reset after bit 11, then a clean reload
    begin_load();
    feed_word(8'hA5, 0);
    data_valid = 1'b1; data_in = 8'h3C;
    for (int i = 0; i < 30; i++) begin
      if (obs.size() >= 11) break;
      cycle();
    end
    nreset = 1'b0;
    cycle();
    nreset = 1'b1;
    check_eq("abort_bits", 32'(obs.size()), 32'd11);
    check_eq("abort_ready", 32'(data_ready), 32'd0);
    check_eq("abort_enable", 32'(config_enable), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    repeat (3) cycle();
    data_valid = 1'b0;
    check_eq("abort_idle_valid_ignored", 32'(obs.size()), 32'd11);
    begin_load();
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    feed_word(w0, 0); feed_word(w1, 0); feed_word(w2, 0);
    wait_done(40);
    words = {w2, w1, w0};
    check_eq("reload_count", 32'(obs.size()), 32'd20);
    check_eq("reload_bits", packed_obs(), 32'(words[19:0]));

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      nreset     = ($urandom_range(63) != 0);
      start      = ($urandom_range(15) == 0);
      data_valid = ($urandom_range(3) != 0);
      data_in    = 8'($urandom);
      cycle();
    end
    nreset = 1'b1; start = 1'b0; data_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
